dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data_mem between the pipeline MEM stage and an external DMA/debug requester.
//  The pipeline has priority. A starvation counter forces a bounded DMA burst, and the pipeline is held via stallM.
//  Sits between EX/MEM outputs, data_mem and the MEM/WB register; readDataM feeds mem_wb unchanged.
// PARAMETERS
//  ADDR_W     32  address width (pipeline, DMA, memory)
//  DATA_W     32  data width
//  MAX_WAIT   4   consecutive conflict cycles before DMA is forced (>=1)
//  BURST_LEN  4   max DMA accesses per forced ownership period (>=1)
// PORTS
//  clk         in   1       single clock; all state on rising edge
//  reset       in   1       asynchronous, active-low (0 = reset)
//  memReadM    in   1       pipeline load in MEM stage
//  memWriteM   in   1       pipeline store in MEM stage
//  addrM       in   ADDR_W  pipeline address (aluResultM)
//  writeDataM  in   DATA_W  pipeline store data
//  readDataM   out  DATA_W  load data to MEM/WB (= mem_rd, combinational)
//  stallM      out  1       hold PC/IF/ID/EX/MEM regs; MEM/WB takes bubble
//  dma_req     in   1       DMA access request, held until granted
//  dma_we      in   1       1 = write, 0 = read
//  dma_addr    in   ADDR_W  DMA address
//  dma_wdata   in   DATA_W  DMA write data
//  dma_gnt     out  1       access performed this cycle (combinational)
//  dma_rvalid  out  1       read data valid, 1 cycle after granted read
//  dma_rdata   out  DATA_W  registered read data
//  mem_we      out  1       data_mem write enable
//  mem_addr    out  ADDR_W  data_mem address
//  mem_wd      out  DATA_W  data_mem write data
//  mem_rd      in   DATA_W  data_mem read data (combinational read)
// BEHAVIOUR
//  - pipe_acc = memReadM|memWriteM. The owner drives mem_addr/mem_wd/mem_we; the non-owner's write is never issued.
//  - Reset (reset=0): state=S_PIPE, wait_cnt=0, burst_cnt=0, dma_rvalid=0, dma_rdata=0.
//    While reset=0: dma_gnt=0, stallM=0, mem_we=0.
//  - S_PIPE:
//    - If pipe_acc: the pipeline owns memory and stallM=0.
//      - If also dma_req: wait_cnt++. When wait_cnt==MAX_WAIT-1 in a conflict cycle -> next S_DMA, wait_cnt=0, burst_cnt=0.
//    - If !pipe_acc && dma_req: opportunistic grant. dma_gnt=1, DMA owns memory, wait_cnt=0, stay S_PIPE.
//    - If !dma_req: wait_cnt=0.
//  - S_DMA:
//    - If dma_req: DMA owns memory, dma_gnt=1, stallM=pipe_acc, burst_cnt++.
//      Go to S_PIPE after the grant with burst_cnt==BURST_LEN-1.
//    - If !dma_req: the pipeline owns memory the same cycle, stallM=0, next S_PIPE.
//  - Granted DMA read: next edge dma_rvalid=1 and dma_rdata=mem_rd of the grant cycle; else dma_rvalid=0 and dma_rdata holds.
//  - Back-to-back DMA reads give back-to-back rvalid. A DMA write produces no rvalid.
//  - Latency: pipeline 0 added cycles when unstalled. Worst-case DMA wait = MAX_WAIT cycles; pipeline worst stall = BURST_LEN.
//  - Counters: wait_cnt width $clog2(MAX_WAIT)+1 and burst_cnt width $clog2(BURST_LEN)+1. Neither wraps: both clear on state change.
//  - Reset mid-burst: immediate return to S_PIPE; a pending rvalid is dropped (0).
//  - dma_req dropped mid-wait: wait_cnt clears and no forced entry occurs.
// STRUCTURE
//  - Package dmem_arb_pkg: state localparams S_PIPE=1'b0, S_DMA=1'b1; owner codes OWN_PIPE/OWN_DMA.
//  - Single module: 2-state FSM, two counters, registered read-return, combinational owner mux.
//  - No sub-module needed.
// TESTING
//  1. Reset: reset=0 with dma_req=1, memWriteM=1 -> mem_we=0, dma_gnt=0, stallM=0, dma_rvalid=0;
//     release -> S_PIPE, wait_cnt=0.
//  2. Idle grant: pipe_acc=0, DMA write 32'h1234_5678 to 0x10 -> dma_gnt=1 same cycle.
//     Then DMA read of 0x10 -> dma_rvalid=1, dma_rdata=32'h1234_5678 the next cycle.
//  3. Starvation, MAX_WAIT=4, BURST_LEN=4: memReadM=1 and dma_req=1 held -> 4 cycles dma_gnt=0, stallM=0.
//     Then 4 cycles dma_gnt=1, stallM=1, then the pipeline resumes with stallM=0.
//  4. Early release: in S_DMA drop dma_req after 2 grants -> same cycle stallM=0 and the pipeline drives mem_addr;
//     next cycle state S_PIPE.
//  5. Write isolation: pipeline store 32'hDEAD_BEEF@0x8 stalled while DMA writes 32'hFEED_FACE@0x8.
//     After the stall the pipeline store completes -> final mem[0x8]=32'hDEAD_BEEF, with no write while stalled.
//  6. Reset mid-burst after 2 DMA reads -> dma_rvalid=0 at once; after release, state S_PIPE and stallM=0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_arb_pkg
//  Brief   : Shared types for the data-memory arbiter (FSM states, owner codes)
//  Revision: 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    // Arbiter state: pipeline-priority mode or forced DMA burst
    typedef enum logic {
        S_PIPE = 1'b0,
        S_DMA  = 1'b1
    } arb_state_t;

    // Which requester drives the data_mem port this cycle
    typedef enum logic {
        OWN_PIPE = 1'b0,
        OWN_DMA  = 1'b1
    } owner_t;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_arbiter_if
//  Brief   : Pipeline MEM-stage, DMA and data_mem signals around the arbiter
//  Revision: 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Pipeline MEM stage
    logic              memReadM;
    logic              memWriteM;
    logic [ADDR_W-1:0] addrM;
    logic [DATA_W-1:0] writeDataM;
    logic [DATA_W-1:0] readDataM;
    logic              stallM;
    // DMA / debug requester
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;
    // data_mem port
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

    // Arbiter view
    modport slave (
        input  memReadM, memWriteM, addrM, writeDataM,
        output readDataM, stallM,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_we, mem_addr, mem_wd,
        input  mem_rd
    );

    // Environment view (pipeline, DMA engine and memory together)
    modport master (
        output memReadM, memWriteM, addrM, writeDataM,
        input  readDataM, stallM,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_we, mem_addr, mem_wd,
        output mem_rd
    );

endinterface : dmem_arbiter_if
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_arbiter
//  Brief   : Shares single-port data_mem between the pipeline MEM stage and a
//            DMA/debug requester. Pipeline has priority; a starvation counter
//            forces a bounded DMA burst while the pipeline is stalled.
//  Revision: 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_LEN = 4
) (
    input  logic           clk,
    input  logic           reset,      // asynchronous, active-low
    dmem_arbiter_if.slave  bus_if
);

    localparam int WAIT_W  = $clog2(MAX_WAIT) + 1;
    localparam int BURST_W = $clog2(BURST_LEN) + 1;
    localparam logic [WAIT_W-1:0]  c_WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
    localparam logic [BURST_W-1:0] c_BURST_LAST = BURST_W'(BURST_LEN - 1);

    arb_state_t         state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               rvalid_q, rvalid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    owner_t             owner;
    logic               pipe_acc;
    logic               gnt_raw;
    logic               stall_raw;
    logic [ADDR_W-1:0]  addr_mux;
    logic [DATA_W-1:0]  wd_mux;
    logic               we_mux;

    assign pipe_acc = bus_if.memReadM | bus_if.memWriteM;

    // State, starvation counter, burst counter and read-return registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_PIPE;
            wait_q   <= '0;
            burst_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            burst_q  <= burst_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next-state, ownership and grant/stall decisions
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        burst_d   = burst_q;
        owner     = OWN_PIPE;
        gnt_raw   = 1'b0;
        stall_raw = 1'b0;
        unique case (state_q)
            S_PIPE: begin
                if (pipe_acc) begin
                    // Pipeline wins; a competing DMA request ages the counter
                    if (bus_if.dma_req) begin
                        if (wait_q == c_WAIT_LAST) begin
                            state_d = S_DMA;
                            wait_d  = '0;
                            burst_d = '0;
                        end else begin
                            wait_d = wait_q + 1'b1;
                        end
                    end else begin
                        wait_d = '0;
                    end
                end else if (bus_if.dma_req) begin
                    // Idle pipeline slot: serve the DMA opportunistically
                    owner   = OWN_DMA;
                    gnt_raw = 1'b1;
                    wait_d  = '0;
                end else begin
                    wait_d = '0;
                end
            end
            S_DMA: begin
                if (bus_if.dma_req) begin
                    owner     = OWN_DMA;
                    gnt_raw   = 1'b1;
                    stall_raw = pipe_acc;
                    if (burst_q == c_BURST_LAST) begin
                        state_d = S_PIPE;
                        burst_d = '0;
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end else begin
                    // DMA gave up early: hand the port straight back
                    state_d = S_PIPE;
                    burst_d = '0;
                end
            end
            default: begin
                state_d = S_PIPE;
                wait_d  = '0;
                burst_d = '0;
            end
        endcase
    end

    // Owner mux onto the memory port; the non-owner's write is never issued
    always_comb begin
        if (owner == OWN_DMA) begin
            addr_mux = bus_if.dma_addr;
            wd_mux   = bus_if.dma_wdata;
            we_mux   = bus_if.dma_we;
        end else begin
            addr_mux = bus_if.addrM;
            wd_mux   = bus_if.writeDataM;
            we_mux   = bus_if.memWriteM;
        end
    end

    // Capture read data of a granted DMA read for return on the next cycle
    always_comb begin
        rvalid_d = gnt_raw & ~bus_if.dma_we;
        rdata_d  = rvalid_d ? bus_if.mem_rd : rdata_q;
    end

    // Strobes are forced low while reset is asserted
    assign bus_if.mem_addr   = addr_mux;
    assign bus_if.mem_wd     = wd_mux;
    assign bus_if.mem_we     = we_mux & reset;
    assign bus_if.dma_gnt    = gnt_raw & reset;
    assign bus_if.stallM     = stall_raw & reset;
    assign bus_if.readDataM  = bus_if.mem_rd;
    assign bus_if.dma_rvalid = rvalid_q;
    assign bus_if.dma_rdata  = rdata_q;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_dmem_arbiter
//  Brief   : Self-checking bench for dmem_arbiter with a behavioural model
//            and a word-addressed data_mem model
//  Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int MW = 4;
    localparam int BL = 4;

    logic clk;
    logic reset;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW), .BURST_LEN(BL)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus.slave)
    );

    // Stimulus variables
    logic        t_rd, t_wr, t_req, t_we;
    logic [31:0] t_addr, t_wd, t_daddr, t_dwd;

    assign bus.memReadM   = t_rd;
    assign bus.memWriteM  = t_wr;
    assign bus.addrM      = t_addr;
    assign bus.writeDataM = t_wd;
    assign bus.dma_req    = t_req;
    assign bus.dma_we     = t_we;
    assign bus.dma_addr   = t_daddr;
    assign bus.dma_wdata  = t_dwd;

    // data_mem: combinational read, write on rising edge
    logic [31:0] mem [0:63];
    assign bus.mem_rd = mem[bus.mem_addr[7:2]];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wd;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // forced    : a starvation-triggered DMA burst is in progress
    // streak    : consecutive cycles the DMA lost to the pipeline
    // done      : DMA accesses already served in the current forced burst
    bit          m_forced;
    int          m_streak, m_done;
    bit          m_rvalid;
    logic [31:0] m_rdata;

    logic        e_dma_owns, e_gnt, e_stall, e_we, pipe_acc;
    logic [31:0] e_addr, e_wd;

    always_comb begin
        pipe_acc   = t_rd | t_wr;
        e_dma_owns = 1'b0;
        e_stall    = 1'b0;
        if (m_forced) begin
            e_dma_owns = t_req;
            e_stall    = t_req && pipe_acc;
        end else begin
            e_dma_owns = t_req && !pipe_acc;
        end
        e_gnt   = e_dma_owns && reset;
        e_stall = e_stall && reset;
        e_we    = reset && (e_dma_owns ? t_we : t_wr);
        e_addr  = e_dma_owns ? t_daddr : t_addr;
        e_wd    = e_dma_owns ? t_dwd : t_wd;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_forced <= 1'b0;
            m_streak <= 0;
            m_done   <= 0;
            m_rvalid <= 1'b0;
            m_rdata  <= '0;
        end else begin
            m_rvalid <= e_gnt && !t_we;
            if (e_gnt && !t_we) m_rdata <= mem[t_daddr[7:2]];
            if (m_forced) begin
                if (t_req) begin
                    m_done <= m_done + 1;
                    if (m_done + 1 == BL) m_forced <= 1'b0;
                end else begin
                    m_forced <= 1'b0;
                end
            end else if (pipe_acc && t_req) begin
                if (m_streak + 1 == MW) begin
                    m_forced <= 1'b1;
                    m_streak <= 0;
                    m_done   <= 0;
                end else begin
                    m_streak <= m_streak + 1;
                end
            end else begin
                m_streak <= 0;
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("dma_gnt",    {31'd0, bus.dma_gnt},    {31'd0, e_gnt});
            check("stallM",     {31'd0, bus.stallM},     {31'd0, e_stall});
            check("mem_we",     {31'd0, bus.mem_we},     {31'd0, e_we});
            check("dma_rvalid", {31'd0, bus.dma_rvalid}, {31'd0, m_rvalid});
            check("dma_rdata",  bus.dma_rdata, m_rdata);
            if (reset && (e_dma_owns || pipe_acc)) check("mem_addr", bus.mem_addr, e_addr);
            if (e_we) check("mem_wd", bus.mem_wd, e_wd);
            if (reset && t_rd && !e_dma_owns) check("readDataM", bus.readDataM, mem[t_addr[7:2]]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_in(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic rq, input logic we, input logic [31:0] da, input logic [31:0] dw);
        t_rd = rd; t_wr = wr; t_addr = a; t_wd = wd;
        t_req = rq; t_we = we; t_daddr = da; t_dwd = dw;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #2;
        // 1. Reset with competing requests
        reset = 1'b0;
        set_in(1'b0, 1'b1, 32'h8, 32'hAAAA_AAAA, 1'b1, 1'b1, 32'h10, 32'h5555_5555);
        chk_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            half();
            check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
            check("rst_gnt",    {31'd0, bus.dma_gnt}, 32'd0);
            check("rst_stall",  {31'd0, bus.stallM}, 32'd0);
            check("rst_rvalid", {31'd0, bus.dma_rvalid}, 32'd0);
            fin();
        end
        reset = 1'b1;
        idle();
        half();
        check("rst_rdata", bus.dma_rdata, 32'h0);
        fin();

        // 2. Idle grant: DMA write then read back
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h10, 32'h1234_5678);
        half();
        check("idle_wr_gnt", {31'd0, bus.dma_gnt}, 32'd1);
        fin();
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
        half();
        check("idle_rd_gnt", {31'd0, bus.dma_gnt}, 32'd1);
        fin();
        idle();
        half();
        check("idle_rvalid", {31'd0, bus.dma_rvalid}, 32'd1);
        check("idle_rdata",  bus.dma_rdata, 32'h1234_5678);
        fin();

        // 3. Starvation: 4 lost cycles, 4 forced grants, then pipeline resumes
        set_in(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
        for (int i = 0; i < MW; i++) begin
            half();
            check("starve_wait_gnt",   {31'd0, bus.dma_gnt}, 32'd0);
            check("starve_wait_stall", {31'd0, bus.stallM}, 32'd0);
            fin();
        end
        for (int i = 0; i < BL; i++) begin
            half();
            check("starve_burst_gnt",   {31'd0, bus.dma_gnt}, 32'd1);
            check("starve_burst_stall", {31'd0, bus.stallM}, 32'd1);
            fin();
        end
        half();
        check("starve_resume_gnt",   {31'd0, bus.dma_gnt}, 32'd0);
        check("starve_resume_stall", {31'd0, bus.stallM}, 32'd0);
        fin();
        idle();
        half();
        fin();

        // 4. Early release after 2 forced grants
        set_in(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
        for (int i = 0; i < MW + 2; i++) begin
            half();
            fin();
        end
        set_in(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h10, 32'h0);
        half();
        check("early_stall", {31'd0, bus.stallM}, 32'd0);
        check("early_gnt",   {31'd0, bus.dma_gnt}, 32'd0);
        check("early_addr",  bus.mem_addr, 32'h20);
        fin();
        t_req = 1'b1;
        half();
        check("early_back_gnt", {31'd0, bus.dma_gnt}, 32'd0);
        fin();
        idle();
        half();
        fin();

        // 5. Write isolation: stalled pipeline store vs DMA store to same word
        set_in(1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h8, 32'hFEED_FACE);
        for (int i = 0; i < MW; i++) begin
            half();
            fin();
        end
        for (int i = 0; i < BL; i++) begin
            half();
            check("iso_stall", {31'd0, bus.stallM}, 32'd1);
            check("iso_wd",    bus.mem_wd, 32'hFEED_FACE);
            fin();
        end
        t_req = 1'b0;
        half();
        check("iso_pipe_we", {31'd0, bus.mem_we}, 32'd1);
        check("iso_pipe_wd", bus.mem_wd, 32'hDEAD_BEEF);
        fin();
        idle();
        half();
        check("iso_final_mem", mem[2], 32'hDEAD_BEEF);
        fin();

        // 6. Reset in the middle of a forced read burst
        set_in(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
        for (int i = 0; i < MW + 2; i++) begin
            half();
            fin();
        end
        check("mid_rvalid_pre", {31'd0, bus.dma_rvalid}, 32'd1);
        reset = 1'b0;
        half();
        check("mid_rvalid", {31'd0, bus.dma_rvalid}, 32'd0);
        check("mid_stall",  {31'd0, bus.stallM}, 32'd0);
        check("mid_gnt",    {31'd0, bus.dma_gnt}, 32'd0);
        fin();
        reset = 1'b1;
        half();
        check("mid_post_stall", {31'd0, bus.stallM}, 32'd0);
        check("mid_post_gnt",   {31'd0, bus.dma_gnt}, 32'd0);
        fin();
        idle();
        half();
        fin();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
